// File: rtl/rx_byte_framer.sv
// RX byte framer: hunts preamble + SFD in the recovered bit stream, reads the PHR length,
// then packs PHR and PSDU bits into bytes for the RX FIFO and reports end-of-frame status.
module rx_byte_framer #(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      PRE_MIN = 8,
   parameter logic [WIDTH-1:0] SFD     = 8'hA7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cdr_lock,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             fifo_full,
   output logic [WIDTH-1:0] byte_out,
   output logic             byte_valid,
   output logic [6:0]       frame_len,
   output logic             frame_done,
   output logic             frame_err,
   output logic             rx_busy
);

   localparam int unsigned ZcW = $clog2(PRE_MIN + 1);
   localparam int unsigned BcW = $clog2(WIDTH);

   localparam logic [ZcW-1:0] PreMinC = ZcW'(PRE_MIN);
   localparam logic [ZcW-1:0] ZcOne   = ZcW'(1);
   localparam logic [BcW-1:0] BitLast = BcW'(WIDTH - 1);
   localparam logic [BcW-1:0] BitOne  = BcW'(1);

   typedef enum logic [2:0] {
      StIdle,
      StHunt,
      StSfd,
      StPhr,
      StPsdu
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [ZcW-1:0]   zero_cnt_q, zero_cnt_d;
   logic [BcW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [6:0]       byte_cnt_q, byte_cnt_d;
   logic             ovf_q, ovf_d;
   logic [6:0]       frame_len_q, frame_len_d;
   logic [WIDTH-1:0] byte_out_q, byte_out_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_err_q, frame_err_d;

   logic             bit_take;
   logic             byte_cmpl;
   logic [WIDTH-1:0] sr_shift;

   // A lock drop wins over a coincident bit strobe: the bit is neither shifted nor counted.
   assign bit_take  = bit_valid & cdr_lock;
   assign sr_shift  = {bit_in, sr_q[WIDTH-1:1]};
   assign byte_cmpl = bit_take && (bit_cnt_q == BitLast);

   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      zero_cnt_d   = zero_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      ovf_d        = ovf_q;
      frame_len_d  = frame_len_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;

      if (bit_take) begin
         sr_d = sr_shift;
      end

      case (state_q)
         StIdle: begin
            if (cdr_lock) begin
               state_d    = StHunt;
               zero_cnt_d = '0;
            end
         end

         StHunt: begin
            if (!cdr_lock) begin
               state_d = StIdle;
            end else if (bit_valid) begin
               if (!bit_in) begin
                  if (zero_cnt_q < PreMinC) begin
                     zero_cnt_d = zero_cnt_q + ZcOne;
                  end
               end else if (zero_cnt_q >= PreMinC) begin
                  state_d   = StSfd;
                  bit_cnt_d = BitOne;
               end else begin
                  zero_cnt_d = '0;
               end
            end
         end

         StSfd: begin
            if (bit_take) begin
               bit_cnt_d = bit_cnt_q + BitOne;
               if (byte_cmpl) begin
                  bit_cnt_d = '0;
                  if (sr_shift == SFD) begin
                     state_d = StPhr;
                  end else begin
                     state_d    = StHunt;
                     zero_cnt_d = '0;
                  end
               end
            end
         end

         StPhr: begin
            if (bit_take) begin
               bit_cnt_d = bit_cnt_q + BitOne;
               if (byte_cmpl) begin
                  bit_cnt_d   = '0;
                  frame_len_d = sr_shift[6:0];
                  if (sr_shift[6:0] == 7'd0) begin
                     frame_done_d = 1'b1;
                     frame_err_d  = 1'b1;
                     state_d      = StHunt;
                     zero_cnt_d   = '0;
                  end else begin
                     if (!fifo_full) begin
                        byte_valid_d = 1'b1;
                        byte_out_d   = sr_shift;
                     end else begin
                        ovf_d = 1'b1;
                     end
                     byte_cnt_d = '0;
                     state_d    = StPsdu;
                  end
               end
            end
         end

         StPsdu: begin
            if (bit_take) begin
               bit_cnt_d = bit_cnt_q + BitOne;
               if (byte_cmpl) begin
                  bit_cnt_d  = '0;
                  byte_cnt_d = byte_cnt_q + 7'd1;
                  if (!fifo_full) begin
                     byte_valid_d = 1'b1;
                     byte_out_d   = sr_shift;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  // Overflow on the final byte itself still marks the frame bad.
                  if (byte_cnt_q + 7'd1 == frame_len_q) begin
                     frame_done_d = 1'b1;
                     frame_err_d  = ovf_q | fifo_full;
                     ovf_d        = 1'b0;
                     byte_cnt_d   = '0;
                     state_d      = StHunt;
                     zero_cnt_d   = '0;
                  end
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Lock loss inside a frame aborts it; any partial byte is discarded.
      if (!cdr_lock && (state_q == StSfd || state_q == StPhr || state_q == StPsdu)) begin
         frame_done_d = 1'b1;
         frame_err_d  = 1'b1;
         state_d      = StIdle;
         ovf_d        = 1'b0;
         bit_cnt_d    = '0;
         byte_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         sr_q         <= '0;
         zero_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         ovf_q        <= 1'b0;
         frame_len_q  <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         zero_cnt_q   <= zero_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         ovf_q        <= ovf_d;
         frame_len_q  <= frame_len_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign frame_len  = frame_len_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign rx_busy    = (state_q == StPhr) || (state_q == StPsdu);

endmodule

// File: tb/tb_rx_byte_framer.sv
// Testbench for rx_byte_framer: expected FIFO writes and end-of-frame events are queued
// as stimulus is driven and matched against the DUT outputs as they appear.
module tb_rx_byte_framer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cdr_lock;
   logic       bit_in;
   logic       bit_valid;
   logic       fifo_full;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic [6:0] frame_len;
   logic       frame_done;
   logic       frame_err;
   logic       rx_busy;

   rx_byte_framer #(
      .WIDTH   (8),
      .PRE_MIN (8),
      .SFD     (8'hA7)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cdr_lock   (cdr_lock),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .fifo_full  (fifo_full),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .frame_len  (frame_len),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .rx_busy    (rx_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       bv;
      logic [7:0] data;
      logic       done;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   logic model_ovf = 1'b0;

   // Scoreboard: every write strobe or frame_done must match the oldest expected event.
   always @(negedge clk) begin
      if (reset_n && (byte_valid || frame_done)) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got bv=%0b byte=%02h done=%0b err=%0b, required none",
                     byte_valid, byte_out, frame_done, frame_err);
         end else begin
            mon_e = exp_q.pop_front();
            if ({byte_valid, frame_done, frame_err} !== {mon_e.bv, mon_e.done, mon_e.err} ||
                (mon_e.bv && byte_out !== mon_e.data)) begin
               n_err++;
               $display("FAIL fifo_event: got bv=%0b byte=%02h done=%0b err=%0b, required bv=%0b byte=%02h done=%0b err=%0b",
                        byte_valid, byte_out, frame_done, frame_err,
                        mon_e.bv, mon_e.data, mon_e.done, mon_e.err);
            end
         end
      end
   end

   task automatic send_bit(input logic b, input logic full);
      @(negedge clk);
      bit_in    = b;
      bit_valid = 1'b1;
      fifo_full = full;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      fifo_full = 1'b0;
      for (int i = 1; i < n; i++) @(negedge clk);
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
   endtask

   task automatic send_raw(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
   endtask

   // One byte headed for the FIFO; the model decides whether it lands or is dropped.
   task automatic send_byte_exp(input logic [7:0] b, input logic full, input logic last);
      if (!full) begin
         exp_q.push_back('{bv: 1'b1, data: b, done: last, err: last & model_ovf});
      end else begin
         model_ovf = 1'b1;
         if (last) exp_q.push_back('{bv: 1'b0, data: 8'h00, done: 1'b1, err: 1'b1});
      end
      if (last) model_ovf = 1'b0;
      for (int i = 0; i < 8; i++) send_bit(b[i], (i == 7) ? full : 1'b0);
   endtask

   task automatic send_frame(input int npre, input logic [6:0] len, input logic [7:0] base,
                             input logic [7:0] step, input logic [15:0] full_mask);
      logic [7:0] d;
      send_zeros(npre);
      send_raw(8'hA7);
      if (len == 7'd0) begin
         exp_q.push_back('{bv: 1'b0, data: 8'h00, done: 1'b1, err: 1'b1});
         send_raw(8'h00);
      end else begin
         send_byte_exp({1'b0, len}, 1'b0, 1'b0);
         d = base;
         for (int i = 0; i < int'(len); i++) begin
            send_byte_exp(d, full_mask[i], i == int'(len) - 1);
            d = d + step;
         end
      end
   endtask

   task automatic settle();
      idle(1);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      cdr_lock  = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({byte_out, byte_valid, frame_len, frame_done, frame_err, rx_busy} !== 19'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got byte=%02h bv=%0b len=%0d done=%0b err=%0b busy=%0b, required all 0",
                  byte_out, byte_valid, frame_len, frame_done, frame_err, rx_busy);
      end
      reset_n = 1'b1;
      idle(2);
   endtask

   task automatic test_reset_mid_psdu();
      cdr_lock = 1'b1;
      idle(2);
      send_zeros(8);
      send_raw(8'hA7);
      send_byte_exp(8'h05, 1'b0, 1'b0);
      send_byte_exp(8'h11, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      @(negedge clk);
      bit_valid = 1'b0;
      reset_n   = 1'b0;
      #1;
      n_vec++;
      if ({byte_out, byte_valid, frame_len, frame_done, frame_err, rx_busy} !== 19'd0) begin
         n_err++;
         $display("FAIL midreset_outputs: got byte=%02h bv=%0b len=%0d done=%0b err=%0b busy=%0b, required all 0",
                  byte_out, byte_valid, frame_len, frame_done, frame_err, rx_busy);
      end
      @(negedge clk);
      reset_n   = 1'b1;
      model_ovf = 1'b0;
      idle(3);
      n_vec++;
      if ({frame_len, frame_done, rx_busy} !== 9'd0) begin
         n_err++;
         $display("FAIL midreset_after: got len=%0d done=%0b busy=%0b, required 0 0 0",
                  frame_len, frame_done, rx_busy);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL midreset_drain: got %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_good_frame();
      send_frame(32, 7'd3, 8'h11, 8'h11, 16'h0000);
      settle();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL good_drain: got %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
      n_vec++;
      if (frame_len !== 7'd3) begin
         n_err++;
         $display("FAIL good_len: got %0d, required 3", frame_len);
      end
      n_vec++;
      if (rx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL good_busy_after: got %0b, required 0", rx_busy);
      end
   endtask

   task automatic test_short_preamble();
      send_zeros(4);
      send_raw(8'hA7);
      idle(3);
      n_vec++;
      if (rx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL short_pre_busy: got %0b, required 0", rx_busy);
      end
      send_zeros(8);
      send_raw(8'hA7);
      idle(1);
      #1;
      n_vec++;
      if (rx_busy !== 1'b1) begin
         n_err++;
         $display("FAIL short_pre_lock: got busy=%0b, required 1", rx_busy);
      end
      send_byte_exp(8'h01, 1'b0, 1'b0);
      send_byte_exp(8'h5A, 1'b0, 1'b1);
      settle();
      n_vec++;
      if (exp_q.size() != 0 || frame_len !== 7'd1) begin
         n_err++;
         $display("FAIL short_pre_frame: got pending=%0d len=%0d, required 0 1",
                  exp_q.size(), frame_len);
         exp_q.delete();
      end
   endtask

   task automatic test_bad_sfd();
      send_zeros(8);
      send_raw(8'hA6);
      send_bit(1'b1, 1'b0);
      idle(3);
      n_vec++;
      if (rx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL bad_sfd_busy: got %0b, required 0", rx_busy);
      end
      send_frame(8, 7'd0, 8'h00, 8'h00, 16'h0000);
      settle();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL zero_len_drain: got %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
      n_vec++;
      if (frame_len !== 7'd0 || rx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_len_state: got len=%0d busy=%0b, required 0 0", frame_len, rx_busy);
      end
   endtask

   task automatic test_overflow();
      send_frame(8, 7'd4, 8'hAA, 8'h11, 16'h0006);
      settle();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL ovf_drain: got %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
      send_frame(8, 7'd1, 8'h55, 8'h00, 16'h0000);
      settle();
      n_vec++;
      if (exp_q.size() != 0 || frame_len !== 7'd1) begin
         n_err++;
         $display("FAIL ovf_recover: got pending=%0d len=%0d, required 0 1", exp_q.size(), frame_len);
         exp_q.delete();
      end
   endtask

   task automatic test_lock_drop();
      send_zeros(8);
      send_raw(8'hA7);
      send_byte_exp(8'h0A, 1'b0, 1'b0);
      send_byte_exp(8'h30, 1'b0, 1'b0);
      send_byte_exp(8'h31, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      exp_q.push_back('{bv: 1'b0, data: 8'h00, done: 1'b1, err: 1'b1});
      model_ovf = 1'b0;
      @(negedge clk);
      cdr_lock  = 1'b0;
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      settle();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL lock_drop_drain: got %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
      n_vec++;
      if (rx_busy !== 1'b0 || frame_len !== 7'd10) begin
         n_err++;
         $display("FAIL lock_drop_state: got busy=%0b len=%0d, required 0 10", rx_busy, frame_len);
      end
      cdr_lock = 1'b1;
      idle(2);
      send_frame(8, 7'd2, 8'hDE, 8'hCF, 16'h0000);
      settle();
      // Lock loss while still hunting must not raise frame_done.
      send_zeros(5);
      cdr_lock = 1'b0;
      idle(3);
      cdr_lock = 1'b1;
      idle(2);
      n_vec++;
      if (exp_q.size() != 0 || frame_len !== 7'd2) begin
         n_err++;
         $display("FAIL relock_frame: got pending=%0d len=%0d, required 0 2", exp_q.size(), frame_len);
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      send_frame(8, 7'd2, 8'h81, 8'h01, 16'h0000);
      send_frame(8, 7'd3, 8'hF0, 8'hFF, 16'h0000);
      settle();
      n_vec++;
      if (exp_q.size() != 0 || frame_len !== 7'd3) begin
         n_err++;
         $display("FAIL back_to_back: got pending=%0d len=%0d, required 0 3", exp_q.size(), frame_len);
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_psdu();
      test_good_frame();
      test_short_preamble();
      test_bad_sfd();
      test_overflow();
      test_lock_drop();
      test_back_to_back();
      idle(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1);
   end

endmodule
